lock_session_ctrl: RTL

LOCK_SESSION_CTRL -- requirements
Module: lock_session_ctrl

---
 rtl/lock_session_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lock_session_ctrl.sv
// Code-entry lock controller.
// A code is typed as a serial stream of b0/b1 presses. A full correct entry
// opens the lock for a fixed time. Repeated wrong entries lead to a timed
// lockout. Every output is a register written by the state machine.
module lock_session_ctrl #(
   parameter int                  CODE_LEN      = 4,
   parameter logic [CODE_LEN-1:0] CODE          = 4'b1010,
   parameter int                  MAX_FAIL      = 3,
   parameter int                  UNLOCK_CYC    = 500,
   parameter int                  LOCKOUT_CYC   = 1000,
   parameter int                  ENTRY_TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       b0,
   input  logic       b1,
   output logic       unlock,
   output logic       led,
   output logic       lockout,
   output logic       alarm,
   output logic [2:0] fail_cnt,
   output logic       busy
);

   // One timer is shared by all states. It is sized so that the longest
   // period fits, and it never counts past its terminal value.
   localparam int TMAX_A = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int TMAX   = (TMAX_A > ENTRY_TIMEOUT) ? TMAX_A : ENTRY_TIMEOUT;
   localparam int TW     = $clog2(TMAX) + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTRY    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;

   state_t              state_reg;
   logic [TW-1:0]       timer_reg;
   logic [CODE_LEN-1:0] entry_reg;
   logic [3:0]          digit_cnt_reg;
   logic [2:0]          fail_cnt_reg;
   logic                unlock_reg;
   logic                lockout_reg;
   logic                alarm_reg;
   logic                busy_reg;

   logic                press_valid;
   logic [CODE_LEN-1:0] entry_base;
   logic [CODE_LEN-1:0] entry_next;
   logic [3:0]          digit_cnt_next;
   logic                entry_complete;
   logic                entry_match;
   logic [2:0]          fail_cnt_next;
   logic                entry_tmo;
   logic                unlock_done;
   logic                lockout_done;

   // A simultaneous b0&b1 is not a press at all.
   assign press_valid = b0 ^ b1;

   // Digit register and count as they would be after accepting this press.
   // From IDLE a new entry always starts from an empty register.
   always_comb begin
      entry_base     = (state_reg == ENTRY) ? entry_reg : '0;
      entry_next     = (entry_base << 1) | CODE_LEN'(b1);
      digit_cnt_next = (state_reg == ENTRY) ? (digit_cnt_reg + 4'd1) : 4'd1;
      entry_complete = (digit_cnt_next == 4'(CODE_LEN));
      entry_match    = (entry_next == CODE);
      fail_cnt_next  = (fail_cnt_reg >= 3'(MAX_FAIL)) ? 3'(MAX_FAIL)
                                                      : (fail_cnt_reg + 3'd1);
   end

   // Terminal counts for the three timed periods.
   assign entry_tmo    = (timer_reg == TW'(ENTRY_TIMEOUT - 1));
   assign unlock_done  = (timer_reg == TW'(UNLOCK_CYC - 1));
   assign lockout_done = (timer_reg == TW'(LOCKOUT_CYC - 1));

   // Session state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         timer_reg     <= '0;
         entry_reg     <= '0;
         digit_cnt_reg <= '0;
         fail_cnt_reg  <= '0;
         unlock_reg    <= 1'b0;
         lockout_reg   <= 1'b0;
         alarm_reg     <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         alarm_reg <= 1'b0;
         case (state_reg)
            IDLE, ENTRY: begin
               if (press_valid) begin
                  timer_reg <= '0;
                  if (!entry_complete) begin
                     state_reg     <= ENTRY;
                     busy_reg      <= 1'b1;
                     entry_reg     <= entry_next;
                     digit_cnt_reg <= digit_cnt_next;
                  end else begin
                     // The completing digit is judged in the same edge.
                     busy_reg      <= 1'b0;
                     entry_reg     <= '0;
                     digit_cnt_reg <= '0;
                     if (entry_match) begin
                        state_reg    <= UNLOCKED;
                        unlock_reg   <= 1'b1;
                        fail_cnt_reg <= '0;
                     end else if (fail_cnt_next == 3'(MAX_FAIL)) begin
                        state_reg    <= LOCKOUT;
                        lockout_reg  <= 1'b1;
                        alarm_reg    <= 1'b1;
                        fail_cnt_reg <= fail_cnt_next;
                     end else begin
                        state_reg    <= IDLE;
                        fail_cnt_reg <= fail_cnt_next;
                     end
                  end
               end else if (state_reg == ENTRY) begin
                  // Idle time between digits; an abandoned entry is dropped
                  // without counting as a failure.
                  if (entry_tmo) begin
                     state_reg     <= IDLE;
                     busy_reg      <= 1'b0;
                     entry_reg     <= '0;
                     digit_cnt_reg <= '0;
                     timer_reg     <= '0;
                  end else begin
                     timer_reg <= timer_reg + 1'b1;
                  end
               end
            end
            UNLOCKED: begin
               // Any real press relocks at once and is otherwise discarded.
               if (press_valid || unlock_done) begin
                  state_reg  <= IDLE;
                  unlock_reg <= 1'b0;
                  timer_reg  <= '0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            LOCKOUT: begin
               // Presses are ignored for the whole lockout period.
               if (lockout_done) begin
                  state_reg    <= IDLE;
                  lockout_reg  <= 1'b0;
                  fail_cnt_reg <= '0;
                  timer_reg    <= '0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               timer_reg     <= '0;
               entry_reg     <= '0;
               digit_cnt_reg <= '0;
               fail_cnt_reg  <= '0;
               unlock_reg    <= 1'b0;
               lockout_reg   <= 1'b0;
               alarm_reg     <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign unlock   = unlock_reg;
   assign led      = unlock_reg;
   assign lockout  = lockout_reg;
   assign alarm    = alarm_reg;
   assign fail_cnt = fail_cnt_reg;
   assign busy     = busy_reg;

endmodule
